// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 2-flop synchroniser, mid-bit sampling, parity/stop checks
// Each received word is presented with a one-cycle valid strobe and sticky-until-next error flags.
module uart_rx #(
   parameter int RATIO_REG_SIZE = 8,
   parameter int DATA_BITS      = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [RATIO_REG_SIZE-1:0] ratio,
   input  logic                      rx_enb,
   input  logic                      parity_en,
   input  logic                      parity_odd,
   input  logic                      UART_RX,
   output logic                      busy,
   output logic                      valid,
   output logic [DATA_BITS-1:0]      data,
   output logic                      parity_err,
   output logic                      frame_err
);

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                    state;
   state_t                    state_next;
   logic                      rx_m;
   logic                      rx_s;
   logic [RATIO_REG_SIZE-1:0] ratio_reg;
   logic [RATIO_REG_SIZE-1:0] ratio_clamped;
   logic [RATIO_REG_SIZE-1:0] half;
   logic [RATIO_REG_SIZE-1:0] prescaler;
   logic [IDX_W-1:0]          bit_idx;
   logic [DATA_BITS-1:0]      data_sr;
   logic                      par_en_r;
   logic                      par_odd_r;
   logic                      par_err_r;
   logic                      sample_pt;
   logic                      last_bit;
   logic                      start_det;

   // Ratios below 2 would leave no distinct mid-bit sample point.
   assign ratio_clamped = (ratio < RATIO_REG_SIZE'(2)) ? RATIO_REG_SIZE'(2) : ratio;
   assign half          = ratio_reg >> 1;
   assign sample_pt     = (prescaler == half);
   assign last_bit      = (bit_idx == IDX_W'(DATA_BITS - 1));
   assign busy          = (state == S_START) || (state == S_DATA) ||
                          (state == S_PARITY) || (state == S_STOP) || valid;

   always_comb begin
      state_next = state;
      start_det  = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_enb && !rx_s) begin
               start_det  = 1'b1;
               state_next = S_START;
            end
         end
         S_START: begin
            if (sample_pt) begin
               state_next = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (sample_pt && last_bit) begin
               state_next = par_en_r ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (sample_pt) begin
               state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (sample_pt) begin
               state_next = rx_s ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            // A held-low line must be released before another start can be seen.
            if (rx_s) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_m       <= 1'b1;
         rx_s       <= 1'b1;
         state      <= S_IDLE;
         ratio_reg  <= RATIO_REG_SIZE'(2);
         prescaler  <= '0;
         bit_idx    <= '0;
         data_sr    <= '0;
         par_en_r   <= 1'b0;
         par_odd_r  <= 1'b0;
         par_err_r  <= 1'b0;
         valid      <= 1'b0;
         data       <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_m  <= UART_RX;
         rx_s  <= rx_m;
         state <= state_next;
         valid <= 1'b0;

         if (start_det) begin
            prescaler <= '0;
         end else if (prescaler >= ratio_reg - RATIO_REG_SIZE'(1)) begin
            prescaler <= '0;
         end else begin
            prescaler <= prescaler + RATIO_REG_SIZE'(1);
         end

         if (start_det) begin
            ratio_reg <= ratio_clamped;
            par_en_r  <= parity_en;
            par_odd_r <= parity_odd;
            bit_idx   <= '0;
         end

         if (state == S_DATA && sample_pt) begin
            data_sr[bit_idx] <= rx_s;
            bit_idx          <= bit_idx + 1'b1;
         end

         if (state == S_PARITY && sample_pt) begin
            par_err_r <= ((^data_sr) ^ rx_s) != par_odd_r;
         end

         if (state == S_STOP && sample_pt) begin
            valid      <= 1'b1;
            data       <= data_sr;
            parity_err <= par_en_r & par_err_r;
            frame_err  <= ~rx_s;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
// Frames are driven bit-serially on the falling clock edge; a monitor records every valid strobe.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] ratio;
   logic       rx_enb;
   logic       parity_en;
   logic       parity_odd;
   logic       UART_RX;
   logic       busy;
   logic       valid;
   logic [7:0] data;
   logic       parity_err;
   logic       frame_err;

   int         checks    = 0;
   int         failures  = 0;
   int         vcount    = 0;
   int         verr      = 0;
   int         cyc       = 0;
   int         vcyc      = 0;
   int         start_cyc = 0;
   int         base      = 0;
   int         ebase     = 0;
   logic [7:0] vdata [0:31];

   uart_rx #(.RATIO_REG_SIZE(8), .DATA_BITS(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ratio      (ratio),
      .rx_enb     (rx_enb),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .UART_RX    (UART_RX),
      .busy       (busy),
      .valid      (valid),
      .data       (data),
      .parity_err (parity_err),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (vcount < 32) vdata[vcount] <= data;
         if (parity_err || frame_err) verr <= verr + 1;
         vcyc   <= cyc;
         vcount <= vcount + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int n);
      UART_RX = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      UART_RX = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int r, input logic pen,
                             input logic pbit, input logic stop);
      start_cyc = cyc;
      send_bit(1'b0, r);
      for (int i = 0; i < 8; i++) send_bit(d[i], r);
      if (pen) send_bit(pbit, r);
      send_bit(stop, r);
      UART_RX = 1'b1;
   endtask

   initial begin
      reset_n    = 1'b0;
      rx_enb     = 1'b1;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      ratio      = 8'd16;
      UART_RX    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_frame_err", frame_err, 0);
      reset_n = 1'b1;
      idle(20);

      // plain frame, busy mid-frame, exact valid latency
      base = vcount;
      fork
         send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1);
         begin
            repeat (80) @(negedge clk);
            check("t1_busy_mid", busy, 1);
         end
      join
      idle(40);
      check("t1_count", vcount - base, 1);
      check("t1_data", data, 8'hA5);
      check("t1_parity_err", parity_err, 0);
      check("t1_frame_err", frame_err, 0);
      check("t1_busy_end", busy, 0);
      check("t1_latency", vcyc - start_cyc, 156);

      // odd parity, correct then wrong parity bit
      parity_en  = 1'b1;
      parity_odd = 1'b1;
      base = vcount;
      send_frame(8'h03, 16, 1'b1, 1'b1, 1'b1);
      idle(40);
      check("t2_count_ok", vcount - base, 1);
      check("t2_data_ok", data, 8'h03);
      check("t2_parity_err_ok", parity_err, 0);
      check("t2_frame_err_ok", frame_err, 0);
      check("t2_latency", vcyc - start_cyc, 172);
      send_frame(8'h03, 16, 1'b1, 1'b0, 1'b1);
      idle(40);
      check("t2_count_bad", vcount - base, 2);
      check("t2_data_bad", data, 8'h03);
      check("t2_parity_err_bad", parity_err, 1);
      parity_en  = 1'b0;
      parity_odd = 1'b0;

      // stop bit low, then line stuck low
      base = vcount;
      send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0);
      UART_RX = 1'b0;
      repeat (80) @(negedge clk);
      check("t3_count", vcount - base, 1);
      check("t3_data", data, 8'h55);
      check("t3_frame_err", frame_err, 1);
      check("t3_parity_err", parity_err, 0);
      check("t3_busy_break", busy, 0);
      idle(40);
      check("t3_count_release", vcount - base, 1);
      send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1);
      idle(40);
      check("t3_count_next", vcount - base, 2);
      check("t3_data_next", data, 8'hC3);
      check("t3_frame_err_next", frame_err, 0);

      // 3-clock glitch is a false start
      base = vcount;
      UART_RX = 1'b0;
      repeat (3) @(negedge clk);
      UART_RX = 1'b1;
      repeat (3) @(negedge clk);
      check("t4_busy_start", busy, 1);
      idle(40);
      check("t4_busy_after", busy, 0);
      check("t4_count_glitch", vcount - base, 0);
      send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1);
      idle(40);
      check("t4_count", vcount - base, 1);
      check("t4_data", data, 8'h3C);

      // reset in the middle of a frame
      base = vcount;
      send_bit(1'b0, 16);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_data_rst", data, 0);
      check("t5_busy_rst", busy, 0);
      reset_n = 1'b1;
      idle(200);
      check("t5_count_abort", vcount - base, 0);
      send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1);
      idle(40);
      check("t5_count", vcount - base, 1);
      check("t5_data", data, 8'h81);

      // receiver disabled ignores the line
      rx_enb = 1'b0;
      base = vcount;
      send_frame(8'h0F, 16, 1'b0, 1'b0, 1'b1);
      idle(40);
      check("t6_count_disabled", vcount - base, 0);
      rx_enb = 1'b1;
      idle(10);

      // back-to-back frames at extreme ratios
      for (int k = 0; k < 2; k++) begin
         int r;
         r = (k == 0) ? 4 : 255;
         ratio = r[7:0];
         idle(10);
         base  = vcount;
         ebase = verr;
         send_frame(8'h00, r, 1'b0, 1'b0, 1'b1);
         send_frame(8'hFF, r, 1'b0, 1'b0, 1'b1);
         send_frame(8'h5A, r, 1'b0, 1'b0, 1'b1);
         idle(3 * r);
         check($sformatf("t7_count_r%0d", r), vcount - base, 3);
         check($sformatf("t7_d0_r%0d", r), vdata[base], 8'h00);
         check($sformatf("t7_d1_r%0d", r), vdata[base + 1], 8'hFF);
         check($sformatf("t7_d2_r%0d", r), vdata[base + 2], 8'h5A);
         check($sformatf("t7_errs_r%0d", r), verr - ebase, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
